imm_gen_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational immediate generator. Sits between fetch and decode/issue. Accepts one 32-bit instruction per cycle over a valid/ready handshake and returns the sign-extended immediate, a format code and a pass-through tag one cycle later. Covers every RV32I/RV64I immediate format plus the CSR zimm. A 2-entry skid buffer gives full throughput under backpressure with a registered in_ready.

---
 rtl/imm_gen_pipe_if.sv | 26 ++
 rtl/imm_gen_pipe.sv | 169 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out bus for imm_gen_pipe.
// Both directions use valid/ready: a beat moves on a rising clk edge where valid && ready are both high.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_out;
    logic [2:0]       fmt_out;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, instr, in_tag, out_ready,
        input  in_ready, out_valid, imm_out, fmt_out, out_tag
    );

    modport slave (
        input  in_valid, instr, in_tag, out_ready,
        output in_ready, out_valid, imm_out, fmt_out, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a 2-entry skid buffer.
// Decode happens before the registers, so imm_out has no combinational path from out_ready.
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 5,
    parameter bit ENABLE_ZIMM = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    imm_gen_pipe_if.slave bus,
    output logic [1:0] o_state
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    logic [31:0]      w_imm32;
    logic [2:0]       w_fmt;
    logic [XLEN-1:0]  w_imm;
    logic             w_unused;

    // Every 32-bit form is built already sign-extended to 32 bits; zimm has bit 31 clear.
    always_comb begin
        w_imm32 = '0;
        w_fmt   = FMT_NONE;
        case (bus.instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_fmt   = FMT_I;
                w_imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
            end
            7'b1110011: begin
                if (!bus.instr[14]) begin
                    w_fmt   = FMT_I;
                    w_imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
                end else if (ENABLE_ZIMM) begin
                    w_fmt   = FMT_Z;
                    w_imm32 = {27'd0, bus.instr[19:15]};
                end
            end
            7'b0100011: begin
                w_fmt   = FMT_S;
                w_imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            end
            7'b1100011: begin
                w_fmt   = FMT_B;
                w_imm32 = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                           bus.instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_fmt   = FMT_U;
                w_imm32 = {bus.instr[31:12], 12'd0};
            end
            7'b1101111: begin
                w_fmt   = FMT_J;
                w_imm32 = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20],
                           bus.instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_imm    = XLEN'($signed(w_imm32));
    assign w_unused = &{1'b0, bus.instr[13:12]};

    state_t           r_state;
    state_t           w_next;
    logic             r_in_ready;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_or;
    logic             w_load_sk;
    logic             w_move_sk;
    logic [XLEN-1:0]  r_or_imm;
    logic [2:0]       r_or_fmt;
    logic [TAG_W-1:0] r_or_tag;
    logic [XLEN-1:0]  r_sk_imm;
    logic [2:0]       r_sk_fmt;
    logic [TAG_W-1:0] r_sk_tag;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_drain  = (r_state != ST_EMPTY) && bus.out_ready;

    // ST_ONE = OR holds a beat; ST_FULL = OR and SK both hold beats.
    always_comb begin
        w_next    = r_state;
        w_load_or = 1'b0;
        w_load_sk = 1'b0;
        w_move_sk = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_or = 1'b1;
                    w_next    = ST_ONE;
                end
            end
            ST_ONE: begin
                case ({w_accept, w_drain})
                    2'b10: begin
                        w_load_sk = 1'b1;
                        w_next    = ST_FULL;
                    end
                    2'b11:   w_load_or = 1'b1;
                    2'b01:   w_next    = ST_EMPTY;
                    default: ;
                endcase
            end
            ST_FULL: begin
                if (w_drain) begin
                    w_move_sk = 1'b1;
                    w_next    = ST_ONE;
                end
            end
            default: w_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != ST_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_or_imm <= '0;
            r_or_fmt <= FMT_NONE;
            r_or_tag <= '0;
            r_sk_imm <= '0;
            r_sk_fmt <= FMT_NONE;
            r_sk_tag <= '0;
        end else begin
            if (w_load_or) begin
                r_or_imm <= w_imm;
                r_or_fmt <= w_fmt;
                r_or_tag <= bus.in_tag;
            end else if (w_move_sk) begin
                r_or_imm <= r_sk_imm;
                r_or_fmt <= r_sk_fmt;
                r_or_tag <= r_sk_tag;
            end
            if (w_load_sk) begin
                r_sk_imm <= w_imm;
                r_sk_fmt <= w_fmt;
                r_sk_tag <= bus.in_tag;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign bus.imm_out   = r_or_imm;
    assign bus.fmt_out   = r_or_fmt;
    assign bus.out_tag   = r_or_tag;
    assign o_state       = r_state;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN=32, XLEN=64, zimm disabled) share one stimulus stream.
// Each instance has its own expected-result queue, filled on accept and drained on output beats.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic [4:0]  in_tag;
    logic        out_ready;
    logic [1:0]  st32, st64, stnz;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_out32 = 0;

    logic [71:0] exp32_q[$];
    logic [71:0] exp64_q[$];
    logic [71:0] expnz_q[$];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) if64 ();
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) ifnz ();

    assign if32.in_valid = in_valid;
    assign if32.instr = instr;
    assign if32.in_tag = in_tag;
    assign if32.out_ready = out_ready;
    assign if64.in_valid = in_valid;
    assign if64.instr = instr;
    assign if64.in_tag = in_tag;
    assign if64.out_ready = out_ready;
    assign ifnz.in_valid = in_valid;
    assign ifnz.instr = instr;
    assign ifnz.in_tag = in_tag;
    assign ifnz.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .ENABLE_ZIMM(1'b1)) dut32 (
        .clk(clk), .rst(rst), .bus(if32), .o_state(st32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .ENABLE_ZIMM(1'b1)) dut64 (
        .clk(clk), .rst(rst), .bus(if64), .o_state(st64));
    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .ENABLE_ZIMM(1'b0)) dutnz (
        .clk(clk), .rst(rst), .bus(ifnz), .o_state(stnz));

    // Reference decode: returns {fmt, imm sign-extended to 64 bits}.
    function automatic logic [66:0] model(input logic [31:0] w, input bit zen);
        logic [63:0] v;
        logic [2:0]  f;
        v = '0;
        f = 3'd0;
        if (w[6:0] == 7'h13 || w[6:0] == 7'h03 || w[6:0] == 7'h67 ||
            (w[6:0] == 7'h73 && !w[14])) begin
            f = 3'd1;
            v = {{52{w[31]}}, w[31:20]};
        end else if (w[6:0] == 7'h73 && zen) begin
            f = 3'd6;
            v = {59'd0, w[19:15]};
        end else if (w[6:0] == 7'h23) begin
            f = 3'd2;
            v = {{52{w[31]}}, w[31:25], w[11:7]};
        end else if (w[6:0] == 7'h63) begin
            f = 3'd3;
            v = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        end else if (w[6:0] == 7'h37 || w[6:0] == 7'h17) begin
            f = 3'd4;
            v = {{32{w[31]}}, w[31:12], 12'd0};
        end else if (w[6:0] == 7'h6f) begin
            f = 3'd5;
            v = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        end
        return {f, v};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nonempty(input string tag, input int size);
        n_vec++;
        assert (size != 0) else begin
            n_err++;
            $error("FAIL %s: observed beat with %0d expected entries queued, expected at least 1", tag, size);
        end
    endtask

    // Scoreboard: push at the negedge before an accepting edge, pop at the negedge before a draining edge.
    always @(negedge clk) begin
        logic [71:0] e;
        if (rst) begin
            exp32_q.delete();
            exp64_q.delete();
            expnz_q.delete();
        end else begin
            if (if32.out_valid && out_ready) begin
                nonempty("x32_spurious", exp32_q.size());
                if (exp32_q.size() != 0) begin
                    e = exp32_q.pop_front();
                    check("x32_imm", 64'(if32.imm_out), {32'd0, e[31:0]});
                    check("x32_fmt", 64'(if32.fmt_out), 64'(e[66:64]));
                    check("x32_tag", 64'(if32.out_tag), 64'(e[71:67]));
                    n_out32++;
                end
            end
            if (if64.out_valid && out_ready) begin
                nonempty("x64_spurious", exp64_q.size());
                if (exp64_q.size() != 0) begin
                    e = exp64_q.pop_front();
                    check("x64_imm", if64.imm_out, e[63:0]);
                    check("x64_fmt", 64'(if64.fmt_out), 64'(e[66:64]));
                    check("x64_tag", 64'(if64.out_tag), 64'(e[71:67]));
                end
            end
            if (ifnz.out_valid && out_ready) begin
                nonempty("nz_spurious", expnz_q.size());
                if (expnz_q.size() != 0) begin
                    e = expnz_q.pop_front();
                    check("nz_imm", 64'(ifnz.imm_out), {32'd0, e[31:0]});
                    check("nz_fmt", 64'(ifnz.fmt_out), 64'(e[66:64]));
                    check("nz_tag", 64'(ifnz.out_tag), 64'(e[71:67]));
                end
            end
            if (in_valid && if32.in_ready) exp32_q.push_back({in_tag, model(instr, 1'b1)});
            if (in_valid && if64.in_ready) exp64_q.push_back({in_tag, model(instr, 1'b1)});
            if (in_valid && ifnz.in_ready) expnz_q.push_back({in_tag, model(instr, 1'b0)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a beat on the input until it is accepted; returns just after the accepting edge.
    task automatic send(input logic [31:0] w, input logic [4:0] t, input bit rnd);
        bit ok;
        int n;
        in_valid = 1'b1;
        instr = w;
        in_tag = t;
        n = 0;
        do begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = if32.in_ready;
            tick();
            n++;
        end while (!ok && n < 40);
        n_vec++;
        assert (ok) else begin
            n_err++;
            $error("FAIL send_timeout tag %0d: observed accepted=%0d expected 1", t, ok);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  ops[12];
        logic [31:0] w;
        int          c;
        int          n;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h0f, 7'h7f};
        in_valid = 1'b0;
        instr = '0;
        in_tag = '0;
        out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(if32.out_valid), 64'd0);
        check("rst_in_ready", 64'(if32.in_ready), 64'd1);
        check("rst_imm", 64'(if32.imm_out), 64'd0);
        check("rst_fmt", 64'(if32.fmt_out), 64'd0);
        check("rst_tag", 64'(if32.out_tag), 64'd0);
        check("rst_state", 64'(st32), 64'd0);
        tick();

        // Single I-type beat, one-cycle latency.
        send(32'h00500093, 5'd3, 1'b0);
        in_valid = 1'b0;
        check("lat_out_valid", 64'(if32.out_valid), 64'd1);
        check("lat_imm", 64'(if32.imm_out), 64'h5);
        check("lat_fmt", 64'(if32.fmt_out), 64'd1);
        check("lat_tag", 64'(if32.out_tag), 64'd3);
        tick();

        // Back-to-back S, B, J with out_ready held high.
        c = n_out32;
        send(32'h0020A2A3, 5'd1, 1'b0);
        check("s_imm", 64'(if32.imm_out), 64'h5);
        check("s_fmt", 64'(if32.fmt_out), 64'd2);
        send(32'h802081E3, 5'd2, 1'b0);
        check("b_imm", 64'(if32.imm_out), 64'hFFFFF802);
        check("b_fmt", 64'(if32.fmt_out), 64'd3);
        send(32'hFFDFF06F, 5'd4, 1'b0);
        in_valid = 1'b0;
        check("j_imm", 64'(if32.imm_out), 64'hFFFFFFFC);
        check("j_fmt", 64'(if32.fmt_out), 64'd5);
        tick();
        @(negedge clk);
        check("stream_count", 64'(n_out32), 64'(c + 3));
        check("stream_idle", 64'(if32.out_valid), 64'd0);
        tick();

        // U-type under XLEN=64, zimm enabled/disabled, CSR register form.
        send(32'h800000B7, 5'd5, 1'b0);
        check("lui64_neg", if64.imm_out, 64'hFFFFFFFF80000000);
        check("lui64_fmt", 64'(if64.fmt_out), 64'd4);
        check("lui32_neg", 64'(if32.imm_out), 64'h80000000);
        send(32'h123450B7, 5'd6, 1'b0);
        check("lui64_pos", if64.imm_out, 64'h0000000012345000);
        send(32'h300FD0F3, 5'd7, 1'b0);
        check("zimm_imm", 64'(if32.imm_out), 64'h1F);
        check("zimm_fmt", 64'(if32.fmt_out), 64'd6);
        check("zimm_off_imm", 64'(ifnz.imm_out), 64'd0);
        check("zimm_off_fmt", 64'(ifnz.fmt_out), 64'd0);
        send(32'h300090F3, 5'd8, 1'b0);
        in_valid = 1'b0;
        check("csrrw_imm", 64'(if32.imm_out), 64'h300);
        check("csrrw_fmt", 64'(if32.fmt_out), 64'd1);
        tick();

        // Backpressure: tags 1,2 fill OR and SK, tag 3 waits.
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00100093;
        in_tag = 5'd1;
        tick();
        instr = 32'h00200093;
        in_tag = 5'd2;
        tick();
        instr = 32'h00300093;
        in_tag = 5'd3;
        @(negedge clk);
        check("bp_in_ready_low", 64'(if32.in_ready), 64'd0);
        check("bp_state_full", 64'(st32), 64'd2);
        check("bp_out_valid", 64'(if32.out_valid), 64'd1);
        repeat (3) begin
            @(negedge clk);
            check("bp_tag_hold", 64'(if32.out_tag), 64'd1);
            check("bp_imm_hold", 64'(if32.imm_out), 64'h1);
            check("bp_ready_hold", 64'(if32.in_ready), 64'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("rel_tag1", 64'(if32.out_tag), 64'd1);
        check("rel_ready1", 64'(if32.in_ready), 64'd0);
        tick();
        @(negedge clk);
        check("rel_tag2", 64'(if32.out_tag), 64'd2);
        check("rel_ready2", 64'(if32.in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("rel_tag3", 64'(if32.out_tag), 64'd3);
        check("rel_valid3", 64'(if32.out_valid), 64'd1);
        tick();
        @(negedge clk);
        check("rel_empty", 64'(if32.out_valid), 64'd0);
        tick();

        // Reset while OR and SK are both full.
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00A00093;
        in_tag = 5'd10;
        tick();
        in_tag = 5'd11;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_full", 64'(st32), 64'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 64'(if32.out_valid), 64'd0);
        check("mid_rst_ready", 64'(if32.in_ready), 64'd1);
        check("mid_rst_tag", 64'(if32.out_tag), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_quiet", 64'(if32.out_valid), 64'd0);
        end
        tick();
        send(32'h00C00093, 5'd12, 1'b0);
        in_valid = 1'b0;
        check("post_rst_tag", 64'(if32.out_tag), 64'd12);
        check("post_rst_imm", 64'(if32.imm_out), 64'hC);
        tick();

        // Random words over all opcode classes with random backpressure.
        for (int i = 0; i < 24; i++) begin
            w = $urandom();
            w[6:0] = ops[$urandom_range(0, 11)];
            send(w, 5'(i), 1'b1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp32_q.size() != 0 || exp64_q.size() != 0 || expnz_q.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        @(negedge clk);
        check("drain_q32", 64'(exp32_q.size()), 64'd0);
        check("drain_q64", 64'(exp64_q.size()), 64'd0);
        check("drain_qnz", 64'(expnz_q.size()), 64'd0);
        check("drain_idle", 64'(if32.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
